// File: rtl/idli_pkg.sv
// Shared types for the sequenced slice ALU.
package idli_pkg;

  // Opcode encoding; 3'd7 is unused and decodes as XOR.
  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluCmp  = 3'd2,
    AluAnd  = 3'd3,
    AluOr   = 3'd4,
    AluXor  = 3'd5,
    AluPass = 3'd6
  } alu_seq_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  // Subtract-style ops invert rhs and seed the carry with 1.
  function automatic logic alu_is_sub(alu_seq_op_t op);
    return (op == AluSub) || (op == AluCmp);
  endfunction

endpackage

// File: rtl/idli_alu_slice_m.sv
// Combinational SLICE_W-wide ALU slice: ripple adder plus logic ops.
module idli_alu_slice_m
  import idli_pkg::*;
#(
  parameter int unsigned SLICE_W = 4
) (
  input  alu_seq_op_t        i_op,
  input  logic [SLICE_W-1:0] i_lhs,
  input  logic [SLICE_W-1:0] i_rhs,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_data,
  output logic               o_cout,
  output logic               o_cmsb
);

  logic [SLICE_W-1:0] w_rhs;
  logic [SLICE_W-1:0] w_sum;
  logic [SLICE_W:0]   w_c;

  // Ripple-carry sum over the slice with optional rhs inversion.
  always_comb begin
    w_rhs  = alu_is_sub(i_op) ? ~i_rhs : i_rhs;
    w_sum  = '0;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < SLICE_W; i++) begin
      w_sum[i]   = i_lhs[i] ^ w_rhs[i] ^ w_c[i];
      w_c[i+1]   = (i_lhs[i] & w_rhs[i]) | (w_c[i] & (i_lhs[i] ^ w_rhs[i]));
    end
  end

  // Result select; logical ops report no carry so the chain is cleared.
  always_comb begin
    o_data = i_lhs ^ i_rhs;
    o_cout = 1'b0;
    o_cmsb = 1'b0;
    case (i_op)
      AluAdd, AluSub, AluCmp: begin
        o_data = w_sum;
        o_cout = w_c[SLICE_W];
        o_cmsb = w_c[SLICE_W-1];
      end
      AluAnd:  o_data = i_lhs & i_rhs;
      AluOr:   o_data = i_lhs | i_rhs;
      AluPass: o_data = i_rhs;
      default: o_data = i_lhs ^ i_rhs;
    endcase
  end

endmodule

// File: rtl/idli_alu_seq_m.sv
// Sequenced ALU: processes a WORD_W-bit op as LSB-first slices and
// delivers registered Z/N/C/V flags after the last slice.
module idli_alu_seq_m
  import idli_pkg::*;
#(
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned WORD_W  = 16
) (
  input  logic               i_alu_gck,
  input  logic               i_alu_rst_n,
  input  logic               i_alu_vld,
  input  logic               i_alu_flush,
  input  alu_seq_op_t        i_alu_op,
  input  logic [SLICE_W-1:0] i_alu_lhs,
  input  logic [SLICE_W-1:0] i_alu_rhs,
  output logic [SLICE_W-1:0] o_alu_data,
  output logic               o_alu_data_vld,
  output logic               o_alu_last,
  output logic               o_alu_busy,
  output alu_flags_t         o_alu_flags,
  output logic               o_alu_flags_vld
);

  localparam int unsigned NUM_SLICES = WORD_W / SLICE_W;
  localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SLICES - 1);

  logic [CNT_W-1:0]   r_cnt;
  alu_seq_op_t        r_op;
  logic               r_carry;
  logic               r_zacc;
  alu_flags_t         r_flags;
  logic               r_flags_vld;

  logic               w_first;
  logic               w_last;
  logic               w_acc;
  alu_seq_op_t        w_op;
  logic               w_cin;
  logic [SLICE_W-1:0] w_data;
  logic               w_cout;
  logic               w_cmsb;
  logic               w_zacc_nxt;

  // Slice position, effective opcode and carry-in for the current slice.
  always_comb begin
    w_first    = (r_cnt == '0);
    w_last     = (r_cnt == CNT_LAST);
    w_acc      = i_alu_vld & ~i_alu_flush;
    w_op       = w_first ? i_alu_op : r_op;
    w_cin      = w_first ? alu_is_sub(w_op) : r_carry;
    w_zacc_nxt = (w_first | r_zacc) & (w_data == '0);
  end

  idli_alu_slice_m #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .i_op   (w_op),
    .i_lhs  (i_alu_lhs),
    .i_rhs  (i_alu_rhs),
    .i_cin  (w_cin),
    .o_data (w_data),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  // Output drive; CMP never requests writeback.
  always_comb begin
    o_alu_data      = w_data;
    o_alu_data_vld  = w_acc & (w_op != AluCmp);
    o_alu_last      = i_alu_vld & w_last;
    o_alu_busy      = (r_cnt != '0);
    o_alu_flags     = r_flags;
    o_alu_flags_vld = r_flags_vld;
  end

  // Slice counter, op latch, carry/zero chain and flag register.
  always_ff @(posedge i_alu_gck) begin
    if (!i_alu_rst_n) begin
      r_cnt       <= '0;
      r_op        <= AluAdd;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_flags     <= '0;
      r_flags_vld <= 1'b0;
    end else if (i_alu_flush) begin
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_flags_vld <= 1'b0;
    end else begin
      r_flags_vld <= 1'b0;
      if (i_alu_vld) begin
        r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        r_carry <= w_cout;
        r_zacc  <= w_zacc_nxt;
        if (w_first) begin
          r_op <= i_alu_op;
        end
        if (w_last) begin
          r_flags.z   <= w_zacc_nxt;
          r_flags.n   <= w_data[SLICE_W-1];
          r_flags.c   <= w_cout;
          r_flags.v   <= w_cmsb ^ w_cout;
          r_flags_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idli_alu_seq_m.sv
module tb_idli_alu_seq_m;
  import idli_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Default instance: 4-bit slices, 16-bit word.
  logic a_vld, a_flush, a_dvld, a_last, a_busy, a_fvld;
  alu_seq_op_t a_op;
  logic [3:0] a_lhs, a_rhs, a_data;
  alu_flags_t a_flags;

  // Wide instance: 8-bit slices, 32-bit word.
  logic b_vld, b_flush, b_dvld, b_last, b_busy, b_fvld;
  alu_seq_op_t b_op;
  logic [7:0] b_lhs, b_rhs, b_data;
  alu_flags_t b_flags;

  // Single-slice instance: 4-bit slice, 4-bit word.
  logic c_vld, c_flush, c_dvld, c_last, c_busy, c_fvld;
  alu_seq_op_t c_op;
  logic [3:0] c_lhs, c_rhs, c_data;
  alu_flags_t c_flags;

  int n_checks = 0;
  int n_errors = 0;

  idli_alu_seq_m #(.SLICE_W(4), .WORD_W(16)) dut_a (
    .i_alu_gck(clk), .i_alu_rst_n(rst_n), .i_alu_vld(a_vld), .i_alu_flush(a_flush),
    .i_alu_op(a_op), .i_alu_lhs(a_lhs), .i_alu_rhs(a_rhs), .o_alu_data(a_data),
    .o_alu_data_vld(a_dvld), .o_alu_last(a_last), .o_alu_busy(a_busy),
    .o_alu_flags(a_flags), .o_alu_flags_vld(a_fvld));

  idli_alu_seq_m #(.SLICE_W(8), .WORD_W(32)) dut_b (
    .i_alu_gck(clk), .i_alu_rst_n(rst_n), .i_alu_vld(b_vld), .i_alu_flush(b_flush),
    .i_alu_op(b_op), .i_alu_lhs(b_lhs), .i_alu_rhs(b_rhs), .o_alu_data(b_data),
    .o_alu_data_vld(b_dvld), .o_alu_last(b_last), .o_alu_busy(b_busy),
    .o_alu_flags(b_flags), .o_alu_flags_vld(b_fvld));

  idli_alu_seq_m #(.SLICE_W(4), .WORD_W(4)) dut_c (
    .i_alu_gck(clk), .i_alu_rst_n(rst_n), .i_alu_vld(c_vld), .i_alu_flush(c_flush),
    .i_alu_op(c_op), .i_alu_lhs(c_lhs), .i_alu_rhs(c_rhs), .o_alu_data(c_data),
    .o_alu_data_vld(c_dvld), .o_alu_last(c_last), .o_alu_busy(c_busy),
    .o_alu_flags(c_flags), .o_alu_flags_vld(c_fvld));

  // Word-level reference for the wide instance: {z,n,c,v,result}.
  function automatic logic [35:0] model32(alu_seq_op_t op, logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      AluAdd: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      AluSub, AluCmp: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      AluAnd:  r = a & b;
      AluOr:   r = a | b;
      AluPass: r = b;
      default: r = a ^ b;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  task automatic a_slice(input alu_seq_op_t op, input logic [3:0] l, input logic [3:0] r,
                         input logic fl);
    @(negedge clk);
    a_vld = 1'b1; a_flush = fl; a_op = op; a_lhs = l; a_rhs = r;
    #1;
  endtask

  task automatic a_idle();
    @(negedge clk);
    a_vld = 1'b0; a_flush = 1'b0; a_lhs = '0; a_rhs = '0;
    #1;
  endtask

  // Four back-to-back slices; reports result, writeback count and pulses seen.
  task automatic a_word(input alu_seq_op_t op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output int dvld_cnt, output int last_cnt,
                        output logic p0, output alu_flags_t f0, output int pmid);
    dvld_cnt = 0; last_cnt = 0; pmid = 0; res = '0;
    p0 = 1'b0; f0 = '0;
    for (int s = 0; s < 4; s++) begin
      a_slice(op, a[4*s +: 4], b[4*s +: 4], 1'b0);
      res[4*s +: 4] = a_data;
      dvld_cnt += int'(a_dvld);
      if (a_last) last_cnt += (s == 3) ? 1 : 100;
      if (s == 0) begin
        p0 = a_fvld; f0 = a_flags;
      end else begin
        pmid += int'(a_fvld);
      end
    end
  endtask

  task automatic b_slice(input alu_seq_op_t op, input logic [7:0] l, input logic [7:0] r);
    @(negedge clk);
    b_vld = 1'b1; b_op = op; b_lhs = l; b_rhs = r;
    #1;
  endtask

  task automatic b_idle();
    @(negedge clk);
    b_vld = 1'b0; b_lhs = '0; b_rhs = '0;
    #1;
  endtask

  task automatic c_slice(input alu_seq_op_t op, input logic [3:0] l, input logic [3:0] r);
    @(negedge clk);
    c_vld = 1'b1; c_op = op; c_lhs = l; c_rhs = r;
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (a_flags !== 4'b0000 || a_fvld !== 1'b0 || a_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state flags=%b fvld=%b busy=%b want 0000/0/0", a_flags, a_fvld, a_busy);
    end
  endtask

  task automatic test_add_overflow();
    logic [15:0] res; int dv, lc, pm; logic p0; alu_flags_t f0;
    a_word(AluAdd, 16'h7FFF, 16'h0001, res, dv, lc, p0, f0, pm);
    n_checks++;
    if (res !== 16'h8000) begin n_errors++; $display("FAIL add_res got %h want 8000", res); end
    n_checks++;
    if (dv !== 4 || lc !== 1 || pm !== 0) begin
      n_errors++; $display("FAIL add_strobes dvld=%0d last=%0d pmid=%0d want 4/1/0", dv, lc, pm);
    end
    a_idle();
    n_checks++;
    if (a_fvld !== 1'b1 || a_flags !== 4'b0101) begin
      n_errors++; $display("FAIL add_flags fvld=%b flags=%b want 1/0101", a_fvld, a_flags);
    end
    a_idle();
    n_checks++;
    if (a_fvld !== 1'b0 || a_flags !== 4'b0101) begin
      n_errors++; $display("FAIL add_pulse_len fvld=%b flags=%b want 0/0101", a_fvld, a_flags);
    end
  endtask

  task automatic test_sub_stall();
    logic [15:0] res; int busy_bad;
    logic [15:0] v;
    v = 16'h1234; busy_bad = 0;
    a_slice(AluSub, v[3:0], v[3:0], 1'b0);   res[3:0]   = a_data;
    a_slice(AluSub, v[7:4], v[7:4], 1'b0);   res[7:4]   = a_data;
    for (int i = 0; i < 3; i++) begin
      a_idle();
      if (a_busy !== 1'b1 || a_fvld !== 1'b0) busy_bad++;
    end
    a_slice(AluAdd, v[11:8], v[11:8], 1'b0); res[11:8]  = a_data;  // op ignored mid-word
    a_slice(AluSub, v[15:12], v[15:12], 1'b0); res[15:12] = a_data;
    n_checks++;
    if (busy_bad !== 0) begin n_errors++; $display("FAIL stall_busy bad=%0d want 0", busy_bad); end
    n_checks++;
    if (res !== 16'h0000) begin n_errors++; $display("FAIL sub_res got %h want 0000", res); end
    a_idle();
    n_checks++;
    if (a_fvld !== 1'b1 || a_flags !== 4'b1010) begin
      n_errors++; $display("FAIL sub_flags fvld=%b flags=%b want 1/1010", a_fvld, a_flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] res; int dv, lc, pm; logic p0; alu_flags_t f0;
    a_word(AluCmp, 16'h0001, 16'h0002, res, dv, lc, p0, f0, pm);
    n_checks++;
    if (dv !== 0) begin n_errors++; $display("FAIL cmp_no_wb dvld=%0d want 0", dv); end
    a_word(AluAnd, 16'hF0F0, 16'h0FF0, res, dv, lc, p0, f0, pm);
    n_checks++;
    if (p0 !== 1'b1 || f0 !== 4'b0100) begin
      n_errors++; $display("FAIL cmp_flags pulse=%b flags=%b want 1/0100", p0, f0);
    end
    n_checks++;
    if (res !== 16'h00F0 || dv !== 4 || pm !== 0) begin
      n_errors++; $display("FAIL and_res got %h dvld=%0d pmid=%0d want 00f0/4/0", res, dv, pm);
    end
    a_idle();
    n_checks++;
    if (a_fvld !== 1'b1 || a_flags !== 4'b0000) begin
      n_errors++; $display("FAIL and_flags fvld=%b flags=%b want 1/0000", a_fvld, a_flags);
    end
  endtask

  task automatic test_flush();
    logic [15:0] res; int dv, lc, pm; logic p0; alu_flags_t f0;
    a_slice(AluAdd, 4'hF, 4'h1, 1'b0);
    a_slice(AluAdd, 4'hF, 4'h0, 1'b0);
    a_slice(AluAdd, 4'hF, 4'h0, 1'b1);
    n_checks++;
    if (a_dvld !== 1'b0) begin n_errors++; $display("FAIL flush_dvld got %b want 0", a_dvld); end
    a_idle();
    n_checks++;
    if (a_busy !== 1'b0 || a_fvld !== 1'b0) begin
      n_errors++; $display("FAIL flush_state busy=%b fvld=%b want 0/0", a_busy, a_fvld);
    end
    a_word(AluAdd, 16'h0003, 16'h0004, res, dv, lc, p0, f0, pm);
    n_checks++;
    if (res !== 16'h0007 || p0 !== 1'b0 || pm !== 0) begin
      n_errors++; $display("FAIL flush_next res=%h p0=%b pmid=%0d want 0007/0/0", res, p0, pm);
    end
    a_idle();
    n_checks++;
    if (a_fvld !== 1'b1 || a_flags !== 4'b0000) begin
      n_errors++; $display("FAIL flush_next_flags fvld=%b flags=%b want 1/0000", a_fvld, a_flags);
    end
  endtask

  task automatic test_reset_midword();
    logic [15:0] res; int dv, lc, pm; logic p0; alu_flags_t f0;
    a_word(AluAdd, 16'hFFFF, 16'h0001, res, dv, lc, p0, f0, pm);
    a_idle();
    n_checks++;
    if (res !== 16'h0000 || a_flags !== 4'b1010) begin
      n_errors++; $display("FAIL carry_wrap res=%h flags=%b want 0000/1010", res, a_flags);
    end
    a_slice(AluSub, 4'h8, 4'h4, 1'b0);
    a_slice(AluSub, 4'h7, 4'h3, 1'b0);
    @(negedge clk);
    a_vld = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (a_flags !== 4'b0000 || a_busy !== 1'b0 || a_fvld !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset flags=%b busy=%b fvld=%b want 0000/0/0", a_flags, a_busy, a_fvld);
    end
    a_word(AluSub, 16'h0005, 16'h0003, res, dv, lc, p0, f0, pm);
    a_idle();
    n_checks++;
    if (res !== 16'h0002 || a_fvld !== 1'b1 || a_flags !== 4'b0010) begin
      n_errors++;
      $display("FAIL post_reset res=%h fvld=%b flags=%b want 0002/1/0010", res, a_fvld, a_flags);
    end
  endtask

  task automatic test_single_slice();
    c_slice(AluAdd, 4'h7, 4'h1);
    n_checks++;
    if (c_data !== 4'h8 || c_last !== 1'b1 || c_fvld !== 1'b0) begin
      n_errors++; $display("FAIL s1_add data=%h last=%b fvld=%b want 8/1/0", c_data, c_last, c_fvld);
    end
    c_slice(AluSub, 4'h3, 4'h3);
    n_checks++;
    if (c_data !== 4'h0 || c_fvld !== 1'b1 || c_flags !== 4'b0101) begin
      n_errors++; $display("FAIL s1_sub data=%h fvld=%b flags=%b want 0/1/0101", c_data, c_fvld, c_flags);
    end
    c_slice(alu_seq_op_t'(3'd7), 4'hC, 4'h3);
    n_checks++;
    if (c_data !== 4'hF || c_fvld !== 1'b1 || c_flags !== 4'b1010) begin
      n_errors++; $display("FAIL s1_unk data=%h fvld=%b flags=%b want f/1/1010", c_data, c_fvld, c_flags);
    end
    @(negedge clk);
    c_vld = 1'b0;
    #1;
    n_checks++;
    if (c_fvld !== 1'b1 || c_flags !== 4'b0100) begin
      n_errors++; $display("FAIL s1_unk_flags fvld=%b flags=%b want 1/0100", c_fvld, c_flags);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (c_fvld !== 1'b0) begin n_errors++; $display("FAIL s1_idle fvld=%b want 0", c_fvld); end
  endtask

  task automatic test_wide();
    alu_seq_op_t ops [6] = '{AluAdd, AluSub, AluAnd, AluOr, AluXor, AluPass};
    alu_seq_op_t op;
    logic [31:0] a, b, res;
    logic [35:0] exp;
    alu_flags_t ef;
    int pm, lc;
    for (int t = 0; t < 10; t++) begin
      case (t)
        0: begin op = AluAdd; a = 32'h7FFF_FFFF; b = 32'h0000_0001; end
        1: begin op = AluSub; a = 32'h0000_0000; b = 32'h0000_0001; end
        2: begin op = AluSub; a = 32'h8000_0000; b = 32'h0000_0001; end
        3: begin op = AluAdd; a = 32'hFFFF_FFFF; b = 32'h0000_0001; end
        default: begin
          op = ops[$urandom_range(5)]; a = $urandom; b = $urandom;
        end
      endcase
      exp = model32(op, a, b);
      ef = exp[35:32];
      pm = 0; lc = 0;
      for (int s = 0; s < 4; s++) begin
        b_slice(op, a[8*s +: 8], b[8*s +: 8]);
        res[8*s +: 8] = b_data;
        pm += int'(b_fvld);
        if (b_last) lc += (s == 3) ? 1 : 100;
      end
      b_idle();
      n_checks++;
      if (res !== exp[31:0] || b_fvld !== 1'b1 || b_flags !== ef || pm !== 0 || lc !== 1) begin
        n_errors++;
        $display("FAIL wide_%0d op=%0d res=%h flags=%b fvld=%b pmid=%0d last=%0d want %h/%b/1/0/1",
                 t, op, res, b_flags, b_fvld, pm, lc, exp[31:0], ef);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_vld = 1'b0; a_flush = 1'b0; a_op = AluAdd; a_lhs = '0; a_rhs = '0;
    b_vld = 1'b0; b_flush = 1'b0; b_op = AluAdd; b_lhs = '0; b_rhs = '0;
    c_vld = 1'b0; c_flush = 1'b0; c_op = AluAdd; c_lhs = '0; c_rhs = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_add_overflow();
    test_sub_stall();
    test_back_to_back();
    test_flush();
    test_reset_midword();
    test_single_slice();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
